// File: rtl/vec_pkg.sv
// Shared definitions for the vector-match result path.
// Holds the default frame/library/descriptor configuration, the score-width
// and index-width helpers, the ratio-test defaults and the result record
// loaded by match_select. No ports (package).
package vec_pkg;

   localparam int CFG_IMG_VEC_NUM = 3;
   localparam int CFG_LIB_VEC_NUM = 4;
   localparam int CFG_VEC_WIDTH   = 32;

   localparam int RATIO_NUM_DEF = 4;
   localparam int RATIO_DEN_DEF = 5;

   // A score counts matching bits, so it ranges 0..VEC_WIDTH inclusive.
   function automatic int score_w(input int vec_width);
      return $clog2(vec_width + 1);
   endfunction

   // Index width for a count of n items; never narrower than one bit.
   function automatic int IDX_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PKG_OUTW  = score_w(CFG_VEC_WIDTH);
   localparam int PKG_IMG_W = IDX_W(CFG_IMG_VEC_NUM);
   localparam int PKG_LIB_W = IDX_W(CFG_LIB_VEC_NUM);

   typedef struct packed {
      logic [PKG_IMG_W-1:0] img_idx;
      logic [PKG_LIB_W-1:0] lib_idx;
      logic [PKG_OUTW-1:0]  best;
      logic [PKG_OUTW-1:0]  second;
      logic                 accept;
      logic                 last;
      logic                 err;
   } match_res_t;

endpackage

// File: rtl/match_select_if.sv
// Bus bundle between the scoring stage, match_select and the result consumer.
// Score side : in_valid/next_ready handshake, in_data (score), in_norm,
//              in_inner_done (last library score), in_outer_done (last of frame).
// Result side: res_valid/res_ready handshake, res_img_idx, res_lib_idx,
//              res_best, res_second, res_accept, res_last, res_err.
// slave  = match_select view, master = scorer/consumer (testbench) view.
interface match_select_if
   import vec_pkg::*;
#(
   parameter int OUTW  = PKG_OUTW,
   parameter int IMG_W = PKG_IMG_W,
   parameter int LIB_W = PKG_LIB_W
);
   logic             in_valid;
   logic             next_ready;
   logic [OUTW-1:0]  in_data;
   logic [OUTW-1:0]  in_norm;
   logic             in_inner_done;
   logic             in_outer_done;

   logic             res_valid;
   logic             res_ready;
   logic [IMG_W-1:0] res_img_idx;
   logic [LIB_W-1:0] res_lib_idx;
   logic [OUTW-1:0]  res_best;
   logic [OUTW-1:0]  res_second;
   logic             res_accept;
   logic             res_last;
   logic             res_err;

   modport slave (
      input  in_valid, in_data, in_norm, in_inner_done, in_outer_done, res_ready,
      output next_ready, res_valid, res_img_idx, res_lib_idx, res_best,
             res_second, res_accept, res_last, res_err
   );

   modport master (
      output in_valid, in_data, in_norm, in_inner_done, in_outer_done, res_ready,
      input  next_ready, res_valid, res_img_idx, res_lib_idx, res_best,
             res_second, res_accept, res_last, res_err
   );
endinterface

// File: rtl/match_select_ratio_check.sv
// match_ratio_check: combinational acceptance test for one image vector.
// Ports: best_i, second_i (best/second-best scores), norm_i (image vector
// norm), accept_o (norm test and ratio test both pass).
module match_ratio_check #(
   parameter int OUTW      = 6,
   parameter int RATIO_NUM = 4,
   parameter int RATIO_DEN = 5
) (
   input  logic [OUTW-1:0] best_i,
   input  logic [OUTW-1:0] second_i,
   input  logic [OUTW-1:0] norm_i,
   output logic            accept_o
);
   // Ratio constants are at most 255, so 8 extra bits hold either product.
   localparam int PW = OUTW + 8;

   logic [PW-1:0] second_scaled;
   logic [PW-1:0] best_scaled;
   logic          norm_ok;
   logic          ratio_ok;

   always_comb begin
      second_scaled = PW'(second_i) * PW'(RATIO_DEN);
      best_scaled   = PW'(best_i) * PW'(RATIO_NUM);
      // Twice the best score must reach the norm.
      norm_ok       = {best_i, 1'b0} >= {1'b0, norm_i};
      ratio_ok      = second_scaled <= best_scaled;
      accept_o      = norm_ok & ratio_ok;
   end
endmodule

// File: rtl/match_select.sv
// match_select: tracks best and second-best library score per image vector,
// applies the norm and ratio tests and emits one registered result per image
// vector. Ports: clk, rst_n (synchronous, active-low), bus (match_select_if
// slave: score beats in, backpressure via next_ready, results out).
module match_select
   import vec_pkg::*;
#(
   parameter int IMG_VEC_N = CFG_IMG_VEC_NUM,
   parameter int LIB_VEC_N = CFG_LIB_VEC_NUM,
   parameter int VEC_WIDTH = CFG_VEC_WIDTH,
   parameter int RATIO_NUM = RATIO_NUM_DEF,
   parameter int RATIO_DEN = RATIO_DEN_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   match_select_if.slave  bus
);
   localparam int OUTW  = score_w(VEC_WIDTH);
   localparam int IMG_W = IDX_W(IMG_VEC_N);
   localparam int LIB_W = IDX_W(LIB_VEC_N);
   localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(IMG_VEC_N - 1);
   localparam logic [LIB_W-1:0] LIB_LAST = LIB_W'(LIB_VEC_N - 1);

   logic [OUTW-1:0]  best_q,     best_d;
   logic [OUTW-1:0]  second_q,   second_d;
   logic [LIB_W-1:0] best_idx_q, best_idx_d;
   logic [LIB_W-1:0] lib_cnt_q,  lib_cnt_d;
   logic [IMG_W-1:0] img_cnt_q,  img_cnt_d;
   match_res_t       res_q,      res_d;
   logic             res_valid_q, res_valid_d;

   logic             next_ready;
   logic             beat_acc;
   logic             vec_end;
   logic [OUTW-1:0]  fold_best;
   logic [OUTW-1:0]  fold_second;
   logic [LIB_W-1:0] fold_idx;
   logic             accept;

   // Any pending result blocks every beat unless it is consumed this cycle.
   assign next_ready = ~res_valid_q | bus.res_ready;
   assign beat_acc   = bus.in_valid & next_ready;
   // Outer-done alone still closes the image vector.
   assign vec_end    = bus.in_inner_done | bus.in_outer_done;

   // Current beat folded into the running best/second; strict compares keep
   // the earliest index on a tie and push a tied score into second.
   always_comb begin
      fold_best   = best_q;
      fold_second = second_q;
      fold_idx    = best_idx_q;
      if (bus.in_data > best_q) begin
         fold_second = best_q;
         fold_best   = bus.in_data;
         fold_idx    = lib_cnt_q;
      end else if (bus.in_data > second_q) begin
         fold_second = bus.in_data;
      end
   end

   match_ratio_check #(
      .OUTW      (OUTW),
      .RATIO_NUM (RATIO_NUM),
      .RATIO_DEN (RATIO_DEN)
   ) u_ratio (
      .best_i   (fold_best),
      .second_i (fold_second),
      .norm_i   (bus.in_norm),
      .accept_o (accept)
   );

   always_comb begin
      best_d      = best_q;
      second_d    = second_q;
      best_idx_d  = best_idx_q;
      lib_cnt_d   = lib_cnt_q;
      img_cnt_d   = img_cnt_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      if (beat_acc && vec_end) begin
         res_d.img_idx = img_cnt_q;
         res_d.lib_idx = fold_idx;
         res_d.best    = fold_best;
         res_d.second  = fold_second;
         res_d.accept  = accept;
         res_d.last    = bus.in_outer_done;
         // lib_cnt never exceeds LIB_LAST, so this is lib_cnt+1 != LIB_VEC_N.
         res_d.err     = (lib_cnt_q != LIB_LAST);
         res_valid_d   = 1'b1;
         best_d        = '0;
         second_d      = '0;
         best_idx_d    = '0;
         lib_cnt_d     = '0;
         img_cnt_d     = (bus.in_outer_done || img_cnt_q == IMG_LAST) ? '0 : img_cnt_q + 1'b1;
      end else begin
         if (bus.res_ready) begin
            res_valid_d = 1'b0;
         end
         if (beat_acc) begin
            best_d     = fold_best;
            second_d   = fold_second;
            best_idx_d = fold_idx;
            if (lib_cnt_q != LIB_LAST) begin
               lib_cnt_d = lib_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         best_q      <= '0;
         second_q    <= '0;
         best_idx_q  <= '0;
         lib_cnt_q   <= '0;
         img_cnt_q   <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         best_q      <= best_d;
         second_q    <= second_d;
         best_idx_q  <= best_idx_d;
         lib_cnt_q   <= lib_cnt_d;
         img_cnt_q   <= img_cnt_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign bus.next_ready  = next_ready;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_img_idx = res_q.img_idx;
   assign bus.res_lib_idx = res_q.lib_idx;
   assign bus.res_best    = res_q.best;
   assign bus.res_second  = res_q.second;
   assign bus.res_accept  = res_q.accept;
   assign bus.res_last    = res_q.last;
   assign bus.res_err     = res_q.err;
endmodule

// File: tb/tb_match_select.sv
// Testbench for match_select: directed vectors from the test plan followed by
// randomized vectors, each compared against a score-list reference model.
module tb_match_select;
   localparam int IMG_N = 3;
   localparam int LIB_N = 4;
   localparam int VW    = 32;
   localparam int RNUM  = 4;
   localparam int RDEN  = 5;
   localparam int OUTW  = 6;
   localparam int IMG_W = 2;
   localparam int LIB_W = 2;

   typedef struct {
      int img; int lib; int best; int second; int accept; int last; int err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   m_img = 0;

   always #5 clk = ~clk;

   match_select_if #(.OUTW(OUTW), .IMG_W(IMG_W), .LIB_W(LIB_W)) bus ();

   match_select #(
      .IMG_VEC_N (IMG_N),
      .LIB_VEC_N (LIB_N),
      .VEC_WIDTH (VW),
      .RATIO_NUM (RNUM),
      .RATIO_DEN (RDEN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: best is the largest score (first occurrence wins), second is
   // the largest of the remaining scores, tests evaluated on those values.
   task automatic model(input int sc[4], input int n, input int norm, input bit outer,
                        output exp_t e);
      int mx, mi, s2;
      mx = 0;
      for (int i = 0; i < n; i++) if (sc[i] > mx) mx = sc[i];
      mi = -1;
      for (int i = 0; i < n; i++) if (mi < 0 && sc[i] == mx) mi = i;
      s2 = 0;
      for (int j = 0; j < n; j++) if (j != mi && sc[j] > s2) s2 = sc[j];
      e.img    = m_img;
      e.lib    = mi;
      e.best   = mx;
      e.second = s2;
      e.accept = ((2 * mx >= norm) && (s2 * RDEN <= mx * RNUM)) ? 1 : 0;
      e.last   = outer ? 1 : 0;
      e.err    = (n != LIB_N) ? 1 : 0;
      m_img    = (outer || m_img == IMG_N - 1) ? 0 : m_img + 1;
   endtask

   task automatic check_res(input exp_t e, input string tag);
      chk({tag, ".valid"},  32'(bus.res_valid),   1);
      chk({tag, ".img"},    32'(bus.res_img_idx), e.img);
      chk({tag, ".lib"},    32'(bus.res_lib_idx), e.lib);
      chk({tag, ".best"},   32'(bus.res_best),    e.best);
      chk({tag, ".second"}, 32'(bus.res_second),  e.second);
      chk({tag, ".accept"}, 32'(bus.res_accept),  e.accept);
      chk({tag, ".last"},   32'(bus.res_last),    e.last);
      chk({tag, ".err"},    32'(bus.res_err),     e.err);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_beat(input int s, input int norm, input bit inner, input bit outer);
      bit ok;
      bus.in_valid      = 1'b1;
      bus.in_data       = OUTW'(s);
      bus.in_norm       = OUTW'(norm);
      bus.in_inner_done = inner;
      bus.in_outer_done = outer;
      ok = 1'b0;
      for (int cyc = 0; cyc < 20 && !ok; cyc++) begin
         @(negedge clk);
         ok = bus.next_ready;
         @(posedge clk);
      end
      #1;
      bus.in_valid      = 1'b0;
      bus.in_inner_done = 1'b0;
      bus.in_outer_done = 1'b0;
      if (!ok) chk("beat_timeout", 0, 1);
   endtask

   task automatic run_vec(input int sc[4], input int n, input int norm, input bit outer,
                          input bit outer_only, input string tag, output exp_t e);
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) send_beat(sc[i], norm, !(outer && outer_only), outer);
         else            send_beat(sc[i], norm, 1'b0, 1'b0);
      end
      model(sc, n, norm, outer, e);
      check_res(e, tag);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".valid"},  32'(bus.res_valid),   0);
      chk({tag, ".img"},    32'(bus.res_img_idx), 0);
      chk({tag, ".lib"},    32'(bus.res_lib_idx), 0);
      chk({tag, ".best"},   32'(bus.res_best),    0);
      chk({tag, ".second"}, 32'(bus.res_second),  0);
      chk({tag, ".flags"},  32'({bus.res_accept, bus.res_last, bus.res_err}), 0);
      chk({tag, ".ready"},  32'(bus.next_ready),  1);
   endtask

   initial begin
      exp_t e, ea, eb;
      int   sc[4];
      int   n, norm;
      bit   outer, oo;

      bus.in_valid      = 1'b0;
      bus.in_data       = '0;
      bus.in_norm       = '0;
      bus.in_inner_done = 1'b0;
      bus.in_outer_done = 1'b0;
      bus.res_ready     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst_n = 1'b1;

      // Tie with best: second takes the tied score, ratio test fails.
      run_vec('{3, 9, 7, 9}, 4, 16, 1'b0, 1'b0, "v1", e);
      @(posedge clk); #1;
      chk("v1.drop", 32'(bus.res_valid), 0);
      run_vec('{2, 12, 5, 1}, 4, 20, 1'b0, 1'b0, "v2", e);
      run_vec('{2, 12, 5, 1}, 4, 30, 1'b0, 1'b0, "v3", e);

      // Backpressure: hold the result, next vector's beat waits.
      run_vec('{4, 8, 6, 2}, 4, 10, 1'b0, 1'b0, "hA", ea);
      bus.res_ready     = 1'b0;
      bus.in_valid      = 1'b1;
      bus.in_data       = OUTW'(11);
      bus.in_norm       = OUTW'(10);
      bus.in_inner_done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold.next_ready", 32'(bus.next_ready), 0);
         check_res(ea, "hold");
         @(posedge clk);
      end
      #1;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid      = 1'b0;
      bus.in_inner_done = 1'b0;
      model('{11, 0, 0, 0}, 1, 10, 1'b0, eb);
      check_res(eb, "nobubble");

      // Short vector flags err.
      run_vec('{5, 7, 0, 0}, 2, 4, 1'b0, 1'b0, "err", e);

      // Full frame, last beat carries outer_done only.
      run_vec('{1, 2, 3, 4}, 4, 6, 1'b0, 1'b0, "f0", e);
      run_vec('{9, 9, 9, 9}, 4, 6, 1'b0, 1'b0, "f1", e);
      run_vec('{0, 0, 0, 20}, 4, 40, 1'b1, 1'b1, "f2", e);
      run_vec('{7, 3, 30, 1}, 4, 12, 1'b0, 1'b0, "after_frame", e);

      // Reset mid-vector discards the partial accumulation.
      send_beat(20, 8, 1'b0, 1'b0);
      send_beat(30, 8, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_img = 0;
      check_idle("midrst");
      run_vec('{1, 6, 6, 2}, 4, 8, 1'b0, 1'b0, "post_rst", e);

      // Randomized vectors.
      for (int v = 0; v < 30; v++) begin
         n     = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) sc[i] = $urandom_range(0, VW);
         norm  = $urandom_range(0, 63);
         outer = ($urandom_range(0, 3) == 0);
         oo    = $urandom_range(0, 1);
         run_vec(sc, n, norm, outer, oo, "rnd", e);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      @(posedge clk); #1;
      chk("end.valid", 32'(bus.res_valid), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
